// File: rtl/key_edge_debounce.sv
// Multi-channel key synchroniser and debouncer with 1-cycle edge pulses.
// Also provides sticky per-channel event flags with ack and overrun for slow consumers.
module key_edge_debounce #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] key_in,
  input  logic [1:0]      edge_mode,
  input  logic [N_CH-1:0] evt_ack,
  output logic [N_CH-1:0] key_level,
  output logic [N_CH-1:0] key_pos,
  output logic [N_CH-1:0] key_neg,
  output logic [N_CH-1:0] evt_pending,
  output logic [N_CH-1:0] evt_overrun
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } edge_mode_e;

  edge_mode_e mode;
  logic       qual_rise;
  logic       qual_fall;

  assign mode = edge_mode_e'(edge_mode);

  always_comb begin
    qual_rise = 1'b0;
    qual_fall = 1'b0;
    case (mode)
      MODE_RISE: qual_rise = 1'b1;
      MODE_FALL: qual_fall = 1'b1;
      MODE_BOTH: begin
        qual_rise = 1'b1;
        qual_fall = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   pos_q;
    logic                   neg_q;
    logic                   pending_q;
    logic                   overrun_q;
    logic                   synced;
    logic                   accept;
    logic                   rise;
    logic                   fall;
    logic                   qual;

    always_ff @(posedge clk) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_in[ch]};
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign accept = (synced != level_q) && (cnt_q == CNT_LAST);
    assign rise   = accept &  synced;
    assign fall   = accept & ~synced;
    assign qual   = (rise & qual_rise) | (fall & qual_fall);

    // Persistence counter: any return to the current level restarts the count.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
      end else if (synced == level_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        cnt_q   <= '0;
        level_q <= synced;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // A new event arriving with its ack keeps pending set without flagging overrun.
    always_ff @(posedge clk) begin
      if (reset) begin
        pos_q     <= 1'b0;
        neg_q     <= 1'b0;
        pending_q <= 1'b0;
        overrun_q <= 1'b0;
      end else begin
        pos_q     <= rise;
        neg_q     <= fall;
        pending_q <= qual | (pending_q & ~evt_ack[ch]);
        overrun_q <= ~evt_ack[ch] & (overrun_q | (qual & pending_q));
      end
    end

    assign key_level[ch]   = level_q;
    assign key_pos[ch]     = pos_q;
    assign key_neg[ch]     = neg_q;
    assign evt_pending[ch] = pending_q;
    assign evt_overrun[ch] = overrun_q;
  end

endmodule

// File: tb/tb_key_edge_debounce.sv
// Bench for key_edge_debounce: directed latency checks plus randomized traffic
// compared against a sample-window reference model.
module tb_key_edge_debounce;

  localparam int N_CH  = 4;
  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int HDEPTH = SYNC + DEB - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_CH-1:0] key_in;
  logic [1:0]      edge_mode;
  logic [N_CH-1:0] evt_ack;
  logic [N_CH-1:0] key_level, key_pos, key_neg, evt_pending, evt_overrun;

  int checks   = 0;
  int failures = 0;

  logic [N_CH-1:0] hist [HDEPTH];
  logic [N_CH-1:0] m_level = '0, m_pos = '0, m_neg = '0, m_pend = '0, m_ovr = '0;

  key_edge_debounce #(
    .N_CH(N_CH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .key_in(key_in), .edge_mode(edge_mode),
    .evt_ack(evt_ack), .key_level(key_level), .key_pos(key_pos),
    .key_neg(key_neg), .evt_pending(evt_pending), .evt_overrun(evt_overrun)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < HDEPTH; i++) hist[i] = '0;

  // hist[k] is the key_in sample taken k+1 edges ago; the synchronised value seen
  // at this edge is hist[SYNC-1]. A level is accepted once the last DEB synced
  // values all differ from it.
  always @(posedge clk) begin
    logic [N_CH-1:0] acc, q;
    if (reset) begin
      for (int i = 0; i < HDEPTH; i++) hist[i] = '0;
      m_level = '0; m_pos = '0; m_neg = '0; m_pend = '0; m_ovr = '0;
    end else begin
      acc = '1;
      for (int k = 0; k < DEB; k++) acc &= hist[SYNC-1+k] ^ m_level;
      m_pos = acc & ~m_level;
      m_neg = acc &  m_level;
      m_level = m_level ^ acc;
      case (edge_mode)
        2'b00:   q = m_pos;
        2'b01:   q = m_neg;
        2'b10:   q = m_pos | m_neg;
        default: q = '0;
      endcase
      m_ovr  = ~evt_ack & (m_ovr | (q & m_pend));
      m_pend = q | (m_pend & ~evt_ack);
      for (int i = HDEPTH-1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = key_in;
    end
  end

  task automatic checkOutput(input string tag, input logic [N_CH-1:0] obs,
                             input logic [N_CH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: observed %b expected %b", tag, $time, obs, exp);
    end
  endtask

  task automatic checkAgainstModel();
    checkOutput("key_level",   key_level,   m_level);
    checkOutput("key_pos",     key_pos,     m_pos);
    checkOutput("key_neg",     key_neg,     m_neg);
    checkOutput("evt_pending", evt_pending, m_pend);
    checkOutput("evt_overrun", evt_overrun, m_ovr);
    checkOutput("pos_neg_excl", key_pos & key_neg, '0);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, sample at the falling edge.
  task automatic applyStimulus(input logic r, input logic [N_CH-1:0] k,
                               input logic [1:0] m, input logic [N_CH-1:0] a);
    reset = r; key_in = k; edge_mode = m; evt_ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  int hold [N_CH];
  logic [N_CH-1:0] kv, av;
  logic [1:0] mv;

  initial begin
    reset = 1'b1; key_in = '0; edge_mode = 2'b00; evt_ack = '0;
    @(negedge clk);
    applyStimulus(1'b1, 4'b0000, 2'b00, 4'b0000);
    checkOutput("reset_level", key_level, 4'b0000);
    checkOutput("reset_pend",  evt_pending, 4'b0000);
    applyStimulus(1'b0, 4'b0000, 2'b00, 4'b0000);

    // Single press on channel 0: level appears after edge SYNC+DEB = 6.
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(1'b0, 4'b0001, 2'b00, 4'b0000);
      checkOutput("lat_level", key_level, (e >= 6) ? 4'b0001 : 4'b0000);
      checkOutput("lat_pos",   key_pos,   (e == 6) ? 4'b0001 : 4'b0000);
      checkOutput("lat_pend",  evt_pending, (e >= 6) ? 4'b0001 : 4'b0000);
      checkOutput("lat_neg",   key_neg,   4'b0000);
      checkAgainstModel();
    end

    // Reset mid-debounce on channel 3 then release low: no pulse ever.
    applyStimulus(1'b0, 4'b1001, 2'b00, 4'b0000);
    applyStimulus(1'b0, 4'b1001, 2'b00, 4'b0000);
    applyStimulus(1'b0, 4'b1001, 2'b00, 4'b0000);
    applyStimulus(1'b1, 4'b1000, 2'b00, 4'b0000);
    for (int e = 0; e < 10; e++) begin
      applyStimulus(1'b0, 4'b0000, 2'b00, 4'b0000);
      checkOutput("rst_mid_level", key_level, 4'b0000);
      checkOutput("rst_mid_pos",   key_pos,   4'b0000);
      checkAgainstModel();
    end

    // All channels at once: simultaneous pulses, then ack channel 1 only.
    for (int e = 1; e <= 6; e++) begin
      applyStimulus(1'b0, 4'b1111, 2'b00, 4'b0000);
      checkAgainstModel();
    end
    checkOutput("all_pos",  key_pos,     4'b1111);
    checkOutput("all_pend", evt_pending, 4'b1111);
    applyStimulus(1'b0, 4'b1111, 2'b00, 4'b0010);
    checkOutput("ack_ch1",  evt_pending, 4'b1101);
    checkAgainstModel();

    // Randomized traffic: per-channel holds of varying length so that both
    // glitches and accepted changes occur, with occasional mode changes, acks and resets.
    for (int c = 0; c < N_CH; c++) hold[c] = 1;
    kv = key_in; mv = 2'b00;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < N_CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          kv[c] = ~kv[c];
          hold[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4))
                                                : int'($urandom_range(5, 14));
        end
      end
      if ($urandom_range(0, 40) == 0) mv = 2'($urandom_range(0, 3));
      for (int c = 0; c < N_CH; c++) av[c] = ($urandom_range(0, 9) == 0);
      applyStimulus(($urandom_range(0, 499) == 0), kv, mv, av);
      checkAgainstModel();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
